// File: rtl/rf_ctx_sequencer.sv
// Context save/restore sequencer: streams R0..R(N-1) between the register file and data memory.
// Build option: define CTX_SAVE_LR_EN to include R6 (LR) in every transfer (N = NREG_BASE+1).
module rf_ctx_sequencer #(
  parameter int NREG_BASE = 6,
  parameter int AW        = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          SAVE_REQ,
  input  logic          RESTORE_REQ,
  input  logic [AW-1:0] BASE_ADDR,
  output logic [2:0]    RF_RA,
  input  logic [7:0]    RF_RD,
  output logic          RF_WE,
  output logic [2:0]    RF_WA,
  output logic [7:0]    RF_WD,
  output logic [AW-1:0] MEM_ADDR,
  output logic [7:0]    MEM_WD,
  output logic          MEM_WE,
  output logic          MEM_RE,
  input  logic [7:0]    MEM_RD,
  output logic          OWN,
  output logic          BUSY,
  output logic          DONE
);

`ifdef CTX_SAVE_LR_EN
  localparam int N = NREG_BASE + 1;
`else
  localparam int N = NREG_BASE;
`endif
  localparam logic [2:0] K_LAST = 3'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_RESTORE,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      k_reg, k_next;
  logic [AW-1:0]   base_reg, base_next;
  logic [AW-1:0]   addr_k;

  assign addr_k = base_reg + AW'(k_reg);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_IDLE;
      k_reg     <= 3'd0;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      base_reg  <= base_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    base_next  = base_reg;
    case (state_reg)
      S_IDLE: begin
        // SAVE has priority; a simultaneous RESTORE is dropped.
        if (SAVE_REQ) begin
          state_next = S_SAVE;
          k_next     = 3'd0;
          base_next  = BASE_ADDR;
        end else if (RESTORE_REQ) begin
          state_next = S_RESTORE;
          k_next     = 3'd0;
          base_next  = BASE_ADDR;
        end
      end
      S_SAVE: begin
        if (k_reg == K_LAST) begin
          state_next = S_FIN;
          k_next     = 3'd0;
        end else begin
          k_next = k_reg + 3'd1;
        end
      end
      S_RESTORE: begin
        if (k_reg == K_LAST) begin
          state_next = S_DRAIN;
        end else begin
          k_next = k_reg + 3'd1;
        end
      end
      S_DRAIN: begin
        state_next = S_FIN;
        k_next     = 3'd0;
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        k_next     = 3'd0;
      end
    endcase
  end

  always_comb begin
    RF_RA    = 3'd0;
    RF_WE    = 1'b0;
    RF_WA    = 3'd0;
    RF_WD    = 8'd0;
    MEM_ADDR = '0;
    MEM_WD   = 8'd0;
    MEM_WE   = 1'b0;
    MEM_RE   = 1'b0;
    OWN      = 1'b0;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    case (state_reg)
      S_SAVE: begin
        RF_RA    = k_reg;
        MEM_ADDR = addr_k;
        MEM_WD   = RF_RD;
        MEM_WE   = 1'b1;
        OWN      = 1'b1;
        BUSY     = 1'b1;
      end
      S_RESTORE: begin
        MEM_ADDR = addr_k;
        MEM_RE   = 1'b1;
        OWN      = 1'b1;
        BUSY     = 1'b1;
        // Write-back trails the read by one cycle; nothing to write on the first read.
        if (k_reg != 3'd0) begin
          RF_WE = 1'b1;
          RF_WA = k_reg - 3'd1;
          RF_WD = MEM_RD;
        end
      end
      S_DRAIN: begin
        RF_WE = 1'b1;
        RF_WA = K_LAST;
        RF_WD = MEM_RD;
        OWN   = 1'b1;
        BUSY  = 1'b1;
      end
      S_FIN: begin
        DONE = 1'b1;
        BUSY = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
